// File: rtl/ledgreen_pwm_driver.sv
// Green-LED PWM dimmer with optional per-LED blinking, behind a 4-register Avalon slave.
// Blink support (mask, period, frame counter, phase) is built only when LEDGREEN_BLINK_EN is defined.
module ledgreen_pwm_driver #(
    parameter int PRESCALE_DIV = 50
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  led_in,
    input  logic [1:0]  address,
    input  logic        chipselect,
    input  logic        write_n,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic [7:0]  led_out
);

    localparam int PW = (PRESCALE_DIV > 1) ? $clog2(PRESCALE_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE_DIV - 1);

    function automatic logic [4:0] sat_duty(input logic [31:0] v);
        if (v > 32'd16)
            sat_duty = 5'd16;
        else
            sat_duty = v[4:0];
    endfunction

    logic [PW-1:0] presc;
    logic [3:0]    pwm_cnt;
    logic [4:0]    duty;
    logic [7:0]    led_q;
    logic [7:0]    blink_mask;
    logic [7:0]    blink_period;
    logic          blink_phase;

    logic wr;
    logic wr_duty;
    logic restart;
    logic tick;
    logic frame_wrap;
    logic pwm_on;

    assign wr         = chipselect & ~write_n;
    assign wr_duty    = wr && (address == 2'd0);
    assign restart    = wr && (address == 2'd3);
    assign tick       = (presc == PRESC_LAST);
    assign frame_wrap = tick && (pwm_cnt == 4'hF);
    assign pwm_on     = ({1'b0, pwm_cnt} < duty);

    // Prescaler and PWM position; restart outranks a coincident tick.
    always_ff @(posedge clk) begin
        if (reset || restart) begin
            presc   <= '0;
            pwm_cnt <= '0;
        end else if (tick) begin
            presc   <= '0;
            pwm_cnt <= pwm_cnt + 4'd1;
        end else begin
            presc   <= presc + PW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset)
            duty <= 5'd16;
        else if (wr_duty)
            duty <= sat_duty(writedata);
    end

`ifdef LEDGREEN_BLINK_EN
    logic [7:0] frame_cnt;
    logic       wr_mask;
    logic       wr_period;

    assign wr_mask   = wr && (address == 2'd1);
    assign wr_period = wr && (address == 2'd2);

    always_ff @(posedge clk) begin
        if (reset) begin
            blink_mask   <= '0;
            blink_period <= '0;
        end else begin
            if (wr_mask)
                blink_mask <= writedata[7:0];
            if (wr_period)
                blink_period <= writedata[7:0];
        end
    end

    // A period write restarts the frame count but leaves the current phase alone.
    always_ff @(posedge clk) begin
        if (reset || restart) begin
            frame_cnt   <= '0;
            blink_phase <= 1'b1;
        end else if (wr_period) begin
            frame_cnt   <= '0;
        end else if (blink_period == 8'd0) begin
            frame_cnt   <= '0;
            blink_phase <= 1'b1;
        end else if (frame_wrap) begin
            if (frame_cnt == blink_period - 8'd1) begin
                frame_cnt   <= '0;
                blink_phase <= ~blink_phase;
            end else begin
                frame_cnt   <= frame_cnt + 8'd1;
            end
        end
    end
`else
    assign blink_mask   = '0;
    assign blink_period = '0;
    assign blink_phase  = 1'b1;
`endif

    // Two-register path: led_in -> led_q -> led_out.
    always_ff @(posedge clk) begin
        if (reset) begin
            led_q   <= '0;
            led_out <= '0;
        end else begin
            led_q   <= led_in;
            led_out <= led_q & {8{pwm_on}} & (~blink_mask | {8{blink_phase}});
        end
    end

    always_comb begin
        readdata = '0;
        case (address)
            2'd0: readdata = {27'd0, duty};
            2'd1: readdata = {24'd0, blink_mask};
            2'd2: readdata = {24'd0, blink_period};
            default: readdata = {27'd0, pwm_cnt, blink_phase};
        endcase
    end

endmodule

// File: tb/tb_ledgreen_pwm_driver.sv
// Bench for ledgreen_pwm_driver: directed scenarios plus randomized register traffic,
// checked every cycle against a cycle-count based reference model.
module tb_ledgreen_pwm_driver;

    localparam int DIV   = 2;
    localparam int FRAME = 16 * DIV;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  led_in;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [7:0]  led_out;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference state: time is counted in cycles since the last restart.
    int         m_cyc;
    int         m_fc;
    logic [4:0] m_duty;
    logic [7:0] m_mask, m_period, m_led_q, m_led_out;
    logic       m_phase;

    ledgreen_pwm_driver #(.PRESCALE_DIV(DIV)) dut (
        .clk(clk), .reset(reset), .led_in(led_in), .address(address),
        .chipselect(chipselect), .write_n(write_n), .writedata(writedata),
        .readdata(readdata), .led_out(led_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model_read(input logic [1:0] a);
        int pwm;
        pwm = (m_cyc / DIV) % 16;
        case (a)
            2'd0: model_read = {27'd0, m_duty};
            2'd1: model_read = {24'd0, m_mask};
            2'd2: model_read = {24'd0, m_period};
            default: model_read = 32'(pwm * 2 + (m_phase ? 1 : 0));
        endcase
    endfunction

    // One clock: predict from the current inputs, clock the DUT, then compare.
    task automatic step();
        int         n_cyc, n_fc, pwm;
        logic [4:0] n_duty;
        logic [7:0] n_mask, n_period, n_led_q, n_led_out;
        logic       n_phase, wr, wrap;
        n_cyc = m_cyc; n_fc = m_fc; n_duty = m_duty; n_mask = m_mask;
        n_period = m_period; n_led_q = m_led_q; n_led_out = m_led_out; n_phase = m_phase;
        wr = chipselect && !write_n;
        if (reset) begin
            n_cyc = 0; n_fc = 0; n_duty = 5'd16; n_mask = 0; n_period = 0;
            n_led_q = 0; n_led_out = 0; n_phase = 1'b1;
        end else begin
            pwm       = (m_cyc / DIV) % 16;
            n_led_out = m_led_q & ((pwm < int'(m_duty)) ? 8'hFF : 8'h00)
                        & (~m_mask | (m_phase ? 8'hFF : 8'h00));
            n_led_q   = led_in;
            wrap      = (m_cyc % FRAME) == FRAME - 1;
            n_cyc     = (m_cyc + 1) % FRAME;
            if (wr && address == 2'd0)
                n_duty = (writedata > 32'd16) ? 5'd16 : writedata[4:0];
`ifdef LEDGREEN_BLINK_EN
            if (wr && address == 2'd1) n_mask = writedata[7:0];
            if (wr && address == 2'd2) n_period = writedata[7:0];
`endif
            if (wr && address == 2'd3) begin
                n_cyc = 0; n_fc = 0; n_phase = 1'b1;
            end
`ifdef LEDGREEN_BLINK_EN
            else if (wr && address == 2'd2) n_fc = 0;
            else if (m_period == 0) begin
                n_fc = 0; n_phase = 1'b1;
            end else if (wrap) begin
                if (m_fc + 1 == int'(m_period)) begin
                    n_fc = 0; n_phase = ~m_phase;
                end else begin
                    n_fc = m_fc + 1;
                end
            end
`endif
        end
        @(posedge clk);
        #1;
        m_cyc = n_cyc; m_fc = n_fc; m_duty = n_duty; m_mask = n_mask;
        m_period = n_period; m_led_q = n_led_q; m_led_out = n_led_out; m_phase = n_phase;
        chk("model_led_out", {24'd0, led_out}, {24'd0, m_led_out});
        chk("model_readdata", readdata, model_read(address));
    endtask

    task automatic wr_reg(input logic [1:0] a, input logic [31:0] d);
        address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
        step();
        chipselect = 1'b0; write_n = 1'b1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1; led_in = 8'h3C; address = 2'd0; chipselect = 1'b0;
        write_n = 1'b1; writedata = 32'd0;
        m_cyc = 0; m_fc = 0; m_duty = 5'd16; m_mask = 0; m_period = 0;
        m_led_q = 0; m_led_out = 0; m_phase = 1'b1;

        // Passthrough and reset state
        step();
        step();
        chk("reset_led_out", {24'd0, led_out}, 32'd0);
        for (int a = 0; a < 4; a++) begin
            address = 2'(a);
            #1;
            chk("reset_reg", readdata, (a == 0) ? 32'd16 : (a == 3) ? 32'd1 : 32'd0);
        end
        reset = 1'b0; led_in = 8'hA5; address = 2'd0;
        step();
        chk("pass_lat1", {24'd0, led_out}, 32'd0);
        step();
        chk("pass_lat2", {24'd0, led_out}, 32'hA5);

        // PWM at duty 4: 8 cycles on, 24 off per 32-cycle frame
        wr_reg(2'd0, 32'd4);
        led_in = 8'hFF;
        step(); step();
        wr_reg(2'd3, 32'd0);
        for (int k = 1; k <= 64; k++) begin
            step();
            chk("pwm_duty4", {24'd0, led_out}, (((k - 1) % 32) < 8) ? 32'hFF : 32'h00);
        end

        // Saturation and duty extremes
        wr_reg(2'd0, 32'd31);
        address = 2'd0;
        #1;
        chk("duty_sat_read", readdata, 32'd16);
        for (int k = 0; k < 40; k++) begin
            step();
            chk("duty16_on", {24'd0, led_out}, 32'hFF);
        end
        wr_reg(2'd0, 32'd0);
        for (int k = 0; k < 40; k++) begin
            step();
            chk("duty0_off", {24'd0, led_out}, 32'h00);
        end
        wr_reg(2'd0, 32'd16);

`ifdef LEDGREEN_BLINK_EN
        // Blink: low nibble gated off every other frame
        wr_reg(2'd1, 32'h0F);
        wr_reg(2'd2, 32'd1);
        wr_reg(2'd3, 32'd0);
        for (int k = 1; k <= 96; k++) begin
            step();
            chk("blink", {24'd0, led_out}, ((((k - 1) / 32) % 2) == 0) ? 32'hFF : 32'hF0);
        end
        address = 2'd1;
        #1;
        chk("mask_read", readdata, 32'h0F);
`else
        wr_reg(2'd1, 32'hFF);
        address = 2'd1;
        #1;
        chk("nomacro_mask_read", readdata, 32'd0);
        for (int k = 0; k < 40; k++) begin
            step();
            chk("nomacro_led", {24'd0, led_out}, 32'hFF);
        end
`endif

        // Restart landing on a tick cycle
        wr_reg(2'd0, 32'd9);
        for (int k = 0; k < 7; k++) step();
        for (int k = 0; k < DIV && (m_cyc % DIV) != DIV - 1; k++) step();
        chk("restart_on_tick_pre", 32'(m_cyc % DIV), 32'(DIV - 1));
        wr_reg(2'd3, 32'd0);
        address = 2'd3;
        #1;
        chk("restart_status", readdata, 32'd1);

        // Reset in the middle of activity
        wr_reg(2'd1, 32'hAA);
        wr_reg(2'd2, 32'd2);
        wr_reg(2'd0, 32'd5);
        for (int k = 0; k < 50; k++) step();
        reset = 1'b1;
        step();
        chk("midreset_led", {24'd0, led_out}, 32'd0);
        for (int a = 0; a < 4; a++) begin
            address = 2'(a);
            #1;
            chk("midreset_reg", readdata, (a == 0) ? 32'd16 : (a == 3) ? 32'd1 : 32'd0);
        end
        reset = 1'b0;

        // Randomized traffic
        for (int k = 0; k < 3000; k++) begin
            led_in  = 8'($urandom);
            address = 2'($urandom_range(0, 3));
            reset   = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 7) == 0) begin
                chipselect = 1'b1; write_n = 1'b0;
                case (address)
                    2'd0: writedata = $urandom_range(0, 40);
                    2'd1: writedata = $urandom;
                    2'd2: writedata = $urandom_range(0, 3);
                    default: writedata = $urandom;
                endcase
            end else begin
                chipselect = 1'($urandom); write_n = 1'b1; writedata = $urandom;
            end
            step();
        end
        reset = 1'b0; chipselect = 1'b0; write_n = 1'b1;
        do_reset();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ledgreen_pwm_driver.md
LEDGREEN_PWM_DRIVER -- requirements
Module: ledgreen_pwm_driver

Interface
REQ-001 SHALL have parameter PRESCALE_DIV, default 50, meaning clk cycles per PWM tick (legal range 2..65535).
REQ-002 SHALL have port clk, input, 1, meaning the single clock; all logic is on its rising edge.
REQ-003 SHALL have port reset, input, 1, meaning reset; it is synchronous and active-high.
REQ-004 SHALL have port led_in, input, 8, meaning the LED pattern from the green-LED PIO out_port.
REQ-005 SHALL have port address, input, 2, meaning the Avalon slave register select.
REQ-006 SHALL have port chipselect, input, 1, meaning the Avalon slave select.
REQ-007 SHALL have port write_n, input, 1, meaning the Avalon write strobe, active-low.
REQ-008 SHALL have port writedata, input, 32, meaning the Avalon write data.
REQ-009 SHALL have port readdata, output, 32, meaning the Avalon read data, combinational and zero-extended.
REQ-010 SHALL have port led_out, output, 8, meaning the registered drive to the LED pins.

Function
REQ-011 SHALL implement this register map: addr0 duty[4:0] (R/W); addr1 blink_mask[7:0] (R/W); addr2 blink_period[7:0] (R/W); addr3 status (read: {pwm_cnt[3:0], blink_phase} in bits [4:0]; write: restart).
REQ-012 SHALL perform a register write only when chipselect=1 and write_n=0, taking effect on the next edge.
REQ-013 SHALL saturate a duty write above 16 to 16.
REQ-014 SHALL use a prescaler counter that counts 0..PRESCALE_DIV-1, wraps to 0, and asserts a one-cycle tick when its value is PRESCALE_DIV-1.
REQ-015 SHALL increment the 4-bit pwm_cnt on each tick and wrap it from 15 to 0; a frame is 16 ticks.
REQ-016 SHALL compute pwm_on as (pwm_cnt < duty): duty 0 gives always off, duty 16 gives always on, and duty N gives N/16 high time.
REQ-017 SHALL register led_in into led_q every cycle.
REQ-018 SHALL set led_out[i] on every edge to led_q[i] & pwm_on & (~blink_mask[i] | blink_phase).
REQ-019 SHALL give a latency from led_in to led_out of exactly 2 cycles when duty=16 and blink_mask=0.
REQ-020 SHALL, when blink_period≠0, increment an 8-bit frame counter at each pwm_cnt wrap; on reaching blink_period it clears the counter and toggles blink_phase.
REQ-021 SHALL, when blink_period=0, hold blink_phase at 1 and hold the frame counter at 0.
REQ-022 SHALL, when blink_period is written, clear the frame counter without changing blink_phase.
REQ-023 SHALL, on a write to addr3, clear the prescaler, pwm_cnt and frame counter and set blink_phase=1 on the next edge.
REQ-024 SHALL let the addr3 restart take priority over a tick or frame event in the same cycle.
REQ-025 SHALL let duty changes take effect on pwm_on from the cycle after the write, with no wait for frame end.

Reset
REQ-026 SHALL, with reset=1 at an edge, set: duty=16, blink_mask=0, blink_period=0, prescaler=0, pwm_cnt=0, frame counter=0, blink_phase=1, led_q=0, led_out=0.
REQ-027 SHALL give reset priority over all writes and counting, and apply it mid-frame with no residual state.
REQ-028 SHALL, after reset release, pass led_in to led_out unmodified with 2-cycle latency.

Configuration
REQ-029 SHALL, when macro LEDGREEN_BLINK_EN is defined, include blink_mask, blink_period, the frame counter and blink_phase as specified.
REQ-030 SHALL, when LEDGREEN_BLINK_EN is undefined, omit the blink logic: addr1 and addr2 read 0 and ignore writes, blink_phase is constant 1, and the status read still reports pwm_cnt.

Verification
REQ-031 SHALL cover passthrough: reset, then led_in=8'hA5 -> led_out=8'hA5 exactly 2 cycles later, and led_out=0 during reset.
REQ-032 SHALL cover PWM: PRESCALE_DIV=2, duty=4, led_in=8'hFF -> led_out=8'hFF for 8 cycles then 8'h00 for 24 cycles, repeating every 32 cycles.
REQ-033 SHALL cover saturation and edges: write duty=31 -> readdata=16 and led_out constant; write duty=0 -> led_out=0 constantly.
REQ-034 SHALL cover blink (macro on): PRESCALE_DIV=2, mask=8'h0F, period=1, led_in=8'hFF, duty=16 -> led_out alternates between 8'hFF and 8'hF0 every 32 cycles.
REQ-035 SHALL cover restart/reset collisions: an addr3 write in the tick cycle -> pwm_cnt=0 and blink_phase=1 the next cycle; reset asserted mid-blink -> all registers at reset values the next cycle.
REQ-036 SHALL cover macro off: a write of 8'hFF to addr1 -> addr1 reads 0 and led_out is unaffected.
